// File: rtl/dual_slope_sequencer.sv
// Conversion sequencer for a dual-slope integrating ADC: auto-zero, run-up,
// de-integration with break-before-make switch control and per-conversion status.
module dual_slope_sequencer #(
  parameter int CNT_WIDTH   = 16,
  parameter int T_AZ        = 1000,
  parameter int T_INT       = 10000,
  parameter int T_DEINT_MAX = 20000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 comp_i,
  input  logic                 sat_hi_i,
  input  logic                 sat_lo_i,
  input  logic                 ref_ok_i,
  output logic                 sw_az_o,
  output logic                 sw_in_o,
  output logic                 sw_refp_o,
  output logic                 sw_refn_o,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [CNT_WIDTH-1:0] result_o,
  output logic                 polarity_o,
  output logic                 ovr_o,
  output logic                 err_o
);

  // The phase timer only ever needs to reach max(T_AZ, T_INT) - 1.
  localparam int T_MAX = (T_AZ > T_INT) ? T_AZ : T_INT;
  localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TMR_W-1:0]     AZ_LAST   = TMR_W'(T_AZ - 1);
  localparam logic [TMR_W-1:0]     INT_LAST  = TMR_W'(T_INT - 1);
  localparam logic [CNT_WIDTH-1:0] DEINT_MAX = CNT_WIDTH'(T_DEINT_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AZ,
    S_BBM1,
    S_INT,
    S_BBM2,
    S_DEINT,
    S_DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [TMR_W-1:0]     timer_reg, timer_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 cl_reg, cl_next;
  logic [CNT_WIDTH-1:0] result_reg, result_next;
  logic                 polarity_reg, polarity_next;
  logic                 ovr_reg, ovr_next;
  logic                 err_reg, err_next;
  logic                 sw_az_reg, sw_az_next;
  logic                 sw_in_reg, sw_in_next;
  logic                 sw_refp_reg, sw_refp_next;
  logic                 sw_refn_reg, sw_refn_next;
  logic                 busy_reg, busy_next;
  logic                 valid_reg, valid_next;
  logic                 ref_lost;
  logic                 sat_any;

  assign ref_lost = ~ref_ok_i;
  assign sat_any  = sat_hi_i | sat_lo_i;
  assign cnt_inc  = cnt_reg + CNT_WIDTH'(1);

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    cnt_next      = cnt_reg;
    cl_next       = cl_reg;
    result_next   = result_reg;
    polarity_next = polarity_reg;
    ovr_next      = ovr_reg;
    err_next      = err_reg;

    unique case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          timer_next = '0;
          ovr_next   = 1'b0;
          err_next   = 1'b0;
          if (ref_lost) begin
            err_next    = 1'b1;
            result_next = '0;
            state_next  = S_DONE;
          end else begin
            state_next = S_AZ;
          end
        end
      end

      S_AZ: begin
        // Saturation is expected while the integrator is being zeroed.
        if (ref_lost) begin
          err_next    = 1'b1;
          result_next = '0;
          state_next  = S_DONE;
        end else if (timer_reg == AZ_LAST) begin
          timer_next = '0;
          state_next = S_BBM1;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end

      S_BBM1: begin
        timer_next = '0;
        state_next = S_INT;
      end

      S_INT: begin
        if (ref_lost || sat_any) begin
          err_next    = ref_lost;
          ovr_next    = sat_any;
          result_next = '0;
          state_next  = S_DONE;
        end else if (timer_reg == INT_LAST) begin
          cl_next       = comp_i;
          polarity_next = ~comp_i;
          state_next    = S_BBM2;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end

      S_BBM2: begin
        cnt_next   = '0;
        state_next = S_DEINT;
      end

      S_DEINT: begin
        // Priority: abort, then zero crossing, then timeout.
        if (ref_lost || sat_any) begin
          err_next    = ref_lost;
          ovr_next    = sat_any;
          result_next = '0;
          state_next  = S_DONE;
        end else if (comp_i != cl_reg) begin
          result_next = cnt_reg;
          state_next  = S_DONE;
        end else if (cnt_inc == DEINT_MAX) begin
          result_next = DEINT_MAX;
          ovr_next    = 1'b1;
          state_next  = S_DONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Outputs are decoded from the state being entered so they are registered
    // yet aligned with the cycle that state is occupied.
    sw_az_next   = (state_next == S_AZ);
    sw_in_next   = (state_next == S_INT);
    sw_refp_next = (state_next == S_DEINT) && !cl_next;
    sw_refn_next = (state_next == S_DEINT) && cl_next;
    busy_next    = (state_next != S_IDLE);
    valid_next   = (state_next == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      cnt_reg      <= '0;
      cl_reg       <= 1'b0;
      result_reg   <= '0;
      polarity_reg <= 1'b0;
      ovr_reg      <= 1'b0;
      err_reg      <= 1'b0;
      sw_az_reg    <= 1'b0;
      sw_in_reg    <= 1'b0;
      sw_refp_reg  <= 1'b0;
      sw_refn_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      cnt_reg      <= cnt_next;
      cl_reg       <= cl_next;
      result_reg   <= result_next;
      polarity_reg <= polarity_next;
      ovr_reg      <= ovr_next;
      err_reg      <= err_next;
      sw_az_reg    <= sw_az_next;
      sw_in_reg    <= sw_in_next;
      sw_refp_reg  <= sw_refp_next;
      sw_refn_reg  <= sw_refn_next;
      busy_reg     <= busy_next;
      valid_reg    <= valid_next;
    end
  end

  assign sw_az_o    = sw_az_reg;
  assign sw_in_o    = sw_in_reg;
  assign sw_refp_o  = sw_refp_reg;
  assign sw_refn_o  = sw_refn_reg;
  assign busy_o     = busy_reg;
  assign valid_o    = valid_reg;
  assign result_o   = result_reg;
  assign polarity_o = polarity_reg;
  assign ovr_o      = ovr_reg;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_dual_slope_sequencer.sv
// Directed bench for dual_slope_sequencer: table-driven full conversions plus
// hand-written abort, error and asynchronous-reset sequences.
module tb_dual_slope_sequencer;

  localparam int CW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          comp_i = 1'b0;
  logic          sat_hi_i = 1'b0;
  logic          sat_lo_i = 1'b0;
  logic          ref_ok_i = 1'b1;
  logic          sw_az_o, sw_in_o, sw_refp_o, sw_refn_o;
  logic          busy_o, valid_o, polarity_o, ovr_o, err_o;
  logic [CW-1:0] result_o;

  int checks = 0;
  int failures = 0;

  dual_slope_sequencer #(
    .CNT_WIDTH  (CW),
    .T_AZ       (4),
    .T_INT      (16),
    .T_DEINT_MAX(32)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .comp_i    (comp_i),
    .sat_hi_i  (sat_hi_i),
    .sat_lo_i  (sat_lo_i),
    .ref_ok_i  (ref_ok_i),
    .sw_az_o   (sw_az_o),
    .sw_in_o   (sw_in_o),
    .sw_refp_o (sw_refp_o),
    .sw_refn_o (sw_refn_o),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .result_o  (result_o),
    .polarity_o(polarity_o),
    .ovr_o     (ovr_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic cl;           // comparator level at the end of INT
    int   n;            // DEINT edge where comp flips (0 = never)
    logic sat_az;       // sat_lo_i held through AZ
    logic start_busy;   // extra start pulse while busy
    int   exp_result;
    logic exp_pol;
    logic exp_ovr;
    int   exp_deint;    // DEINT cycles
    int   exp_valid_c;  // cycle index (1 = first after start edge) of valid
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Break-before-make: never two switches at once, never a direct hand-over.
  logic [3:0] sw_prev = 4'b0;
  always @(negedge clk_i) begin
    logic [3:0] sw_now;
    sw_now = {sw_az_o, sw_in_o, sw_refp_o, sw_refn_o};
    checks++;
    if (!$onehot0(sw_now) || (sw_prev != 4'b0 && sw_now != 4'b0 && sw_prev != sw_now)) begin
      failures++;
      $display("FAIL switch_overlap actual=%b previous=%b required=one_closed_with_gap", sw_now, sw_prev);
    end
    sw_prev = sw_now;
  end

  // Caller is at a negedge; returns at the negedge of the first cycle after the start edge.
  task automatic start_conv(input logic ref_ok);
    start_i  = 1'b1;
    ref_ok_i = ref_ok;
    @(negedge clk_i);
    start_i  = 1'b0;
    ref_ok_i = 1'b1;
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int az_c = 0, in_c = 0, refn_c = 0, refp_c = 0;
    int first_in = 0, first_dn = 0, valid_c = 0, valid_n = 0, busy_bad = 0;
    logic [CW-1:0] res = '0;
    logic pol = 1'b0, ovr = 1'b0, err = 1'b0;
    string p;
    p = $sformatf("v%0d", idx);
    comp_i   = v.cl;
    ref_ok_i = 1'b1;
    start_i  = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk_i);
      start_i  = v.start_busy && (c == 10);
      sat_lo_i = v.sat_az && (c <= 4);
      if (sw_az_o) az_c++;
      if (sw_in_o) begin
        in_c++;
        if (first_in == 0) first_in = c;
      end
      if (sw_refn_o || sw_refp_o) begin
        if (first_dn == 0) first_dn = c;
      end
      if (sw_refn_o) refn_c++;
      if (sw_refp_o) refp_c++;
      if (valid_o) begin
        valid_n++;
        if (valid_c == 0) begin
          valid_c = c;
          res = result_o;
          pol = polarity_o;
          ovr = ovr_o;
          err = err_o;
        end
      end
      if (valid_c == 0 && !busy_o) busy_bad++;
      if (valid_c != 0 && c == valid_c + 1) begin
        chk({p, "_idle_after_done"}, 32'({busy_o, sw_az_o, sw_in_o, sw_refp_o, sw_refn_o}), 32'd0);
        break;
      end
      comp_i = (v.n != 0 && c >= 22 + v.n) ? ~v.cl : v.cl;
    end
    sat_lo_i = 1'b0;
    start_i  = 1'b0;
    chk({p, "_az_len"},     32'(az_c), 32'd4);
    chk({p, "_int_start"},  32'(first_in), 32'd6);
    chk({p, "_int_len"},    32'(in_c), 32'd16);
    chk({p, "_deint_start"}, 32'(first_dn), 32'd23);
    chk({p, "_refn_len"},   32'(refn_c), v.cl ? 32'(v.exp_deint) : 32'd0);
    chk({p, "_refp_len"},   32'(refp_c), v.cl ? 32'd0 : 32'(v.exp_deint));
    chk({p, "_valid_cycle"}, 32'(valid_c), 32'(v.exp_valid_c));
    chk({p, "_valid_pulses"}, 32'(valid_n), 32'd1);
    chk({p, "_busy"},       32'(busy_bad), 32'd0);
    chk({p, "_result"},     32'(res), 32'(v.exp_result));
    chk({p, "_polarity"},   32'(pol), 32'(v.exp_pol));
    chk({p, "_ovr"},        32'(ovr), 32'(v.exp_ovr));
    chk({p, "_err"},        32'(err), 32'd0);
    $display("vector %0d: result=%0d pol=%0d ovr=%0d err=%0d valid_cycle=%0d", idx, res, pol, ovr, err, valid_c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            cl    n   sat  sbusy res pol   ovr  deint valid
    vecs[0] = '{1'b1, 10, 1'b0, 1'b0,  9, 1'b0, 1'b0, 10, 33};
    vecs[1] = '{1'b0,  1, 1'b0, 1'b0,  0, 1'b1, 1'b0,  1, 24};
    vecs[2] = '{1'b1,  0, 1'b0, 1'b0, 32, 1'b0, 1'b1, 32, 55};
    vecs[3] = '{1'b1,  5, 1'b1, 1'b1,  4, 1'b0, 1'b0,  5, 28};
    vecs[4] = '{1'b0, 32, 1'b0, 1'b0, 31, 1'b1, 1'b0, 32, 55};

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("reset_outputs", 32'({sw_az_o, sw_in_o, sw_refp_o, sw_refn_o, busy_o, valid_o,
                              polarity_o, ovr_o, err_o}), 32'd0);
    chk("reset_result", 32'(result_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 5; i++) begin
      run_vector(vecs[i], i);
      @(negedge clk_i);
    end

    // sat_hi_i during the 5th INT cycle (cycle 10) aborts into DONE at cycle 11
    comp_i = 1'b1;
    start_conv(1'b1);
    repeat (9) @(negedge clk_i);
    chk("sathi_in_int", 32'(sw_in_o), 32'd1);
    sat_hi_i = 1'b1;
    @(negedge clk_i);
    sat_hi_i = 1'b0;
    chk("sathi_valid", 32'(valid_o), 32'd1);
    chk("sathi_ovr", 32'(ovr_o), 32'd1);
    chk("sathi_err", 32'(err_o), 32'd0);
    chk("sathi_result", 32'(result_o), 32'd0);
    $display("sat_hi abort: result=%0d ovr=%0d err=%0d", result_o, ovr_o, err_o);
    @(negedge clk_i);
    chk("sathi_idle", 32'({busy_o, valid_o}), 32'd0);
    @(negedge clk_i);

    // ref_ok_i low at start: DONE on the very next cycle with err
    start_conv(1'b0);
    chk("noref_valid", 32'(valid_o), 32'd1);
    chk("noref_err", 32'(err_o), 32'd1);
    chk("noref_switches", 32'({sw_az_o, sw_in_o, sw_refp_o, sw_refn_o}), 32'd0);
    $display("ref not ready at start: valid=%0d err=%0d", valid_o, err_o);
    @(negedge clk_i);
    chk("noref_idle", 32'({busy_o, valid_o}), 32'd0);
    @(negedge clk_i);

    // ref_ok_i drop together with sat_lo_i in the 3rd DEINT cycle
    comp_i = 1'b1;
    start_conv(1'b1);
    chk("both_err_cleared", 32'(err_o), 32'd0);
    repeat (24) @(negedge clk_i);
    chk("both_in_deint", 32'(sw_refn_o), 32'd1);
    ref_ok_i = 1'b0;
    sat_lo_i = 1'b1;
    @(negedge clk_i);
    ref_ok_i = 1'b1;
    sat_lo_i = 1'b0;
    chk("both_valid", 32'(valid_o), 32'd1);
    chk("both_err", 32'(err_o), 32'd1);
    chk("both_ovr", 32'(ovr_o), 32'd1);
    chk("both_result", 32'(result_o), 32'd0);
    $display("ref lost + sat_lo in DEINT: result=%0d ovr=%0d err=%0d", result_o, ovr_o, err_o);
    @(negedge clk_i);
    @(negedge clk_i);

    // Leave result=31, polarity=1 so the reset check below is meaningful
    run_vector(vecs[4], 5);
    @(negedge clk_i);

    // Asynchronous reset in the middle of INT
    comp_i = 1'b1;
    start_conv(1'b1);
    repeat (9) @(negedge clk_i);
    chk("rst_pre_in", 32'(sw_in_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_async_switches", 32'({sw_az_o, sw_in_o, sw_refp_o, sw_refn_o}), 32'd0);
    chk("rst_async_flags", 32'({busy_o, valid_o, polarity_o, ovr_o, err_o}), 32'd0);
    chk("rst_async_result", 32'(result_o), 32'd0);
    $display("async reset mid-INT: sw_in=%0d busy=%0d result=%0d", sw_in_o, busy_o, result_o);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_stays_idle", 32'({busy_o, sw_az_o}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
